udma_stream_rd_arbiter: RTL and testbench
=========================================

Name: udma_stream_rd_arbiter

Overview:
- Shares one L2 read channel (req/gnt + valid/ready, uDMA tx-channel protocol) among N_STREAMS stream units.
- Each stream unit prefetches buffered stream data from L2 through its own tx-channel port.
- Round-robin arbitration on the request phase.
- Each grant's requester ID is recorded in an in-order ID FIFO, so returned data is steered back to the correct requester.
- Sits between the stream units and the uDMA core's L2 tx-channel arbiter.

Parameters:
- N_STREAMS, 4: number of requesting stream units; minimum 2.
- L2_AWIDTH_NOAL, 16: L2 address width.
- DATA_WIDTH, 32: read data width.
- MAX_OUTSTANDING, 4: ID FIFO depth, i.e. maximum granted-but-unanswered reads; power of two.
- ID_W, $clog2(N_STREAMS): requester index width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous, active-low reset.
- clr_i  in  1  synchronous clear: flushes ID FIFO, priority pointer and error flag.
- req_i  in  N_STREAMS  per-stream read request.
- addr_i  in  N_STREAMS*L2_AWIDTH_NOAL  per-stream address, stream k at slice k.
- datasize_i  in  N_STREAMS*2  per-stream datasize.
- gnt_o  out  N_STREAMS  per-stream grant, one-hot or zero.
- valid_o  out  N_STREAMS  per-stream response valid, one-hot or zero.
- data_o  out  DATA_WIDTH  response data, shared by all streams.
- ready_i  in  N_STREAMS  per-stream response ready.
- l2_req_o  out  1  request to L2 channel.
- l2_addr_o  out  L2_AWIDTH_NOAL  address of the arbitration winner.
- l2_datasize_o  out  2  datasize of the arbitration winner.
- l2_gnt_i  in  1  L2 grant.
- l2_valid_i  in  1  L2 response valid.
- l2_data_i  in  DATA_WIDTH  L2 response data.
- l2_ready_o  out  1  response ready to L2.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current ID FIFO fill level.
- err_o  out  1  sticky: response received with empty ID FIFO.

Behaviour:
- Reset and clear values:
  - Registers: r_prio=0, FIFO wr/rd pointers=0, r_count=0, r_err=0.
  - Output consequences: gnt_o=0, l2_req_o=0, valid_o=0, outstanding_o=0, err_o=0.
  - l2_ready_o resets to 1, because the FIFO is empty.
- Arbitration (combinational, zero latency):
  - winner = first k with req_i[k]=1, scanning k = r_prio, r_prio+1, … mod N_STREAMS.
  - l2_req_o = |req_i & !full & !clr_i.
  - l2_addr_o and l2_datasize_o carry the winner's slices; value is don't-care when l2_req_o=0.
- Grant:
  - gnt_o[winner] = l2_req_o & l2_gnt_i.
  - On that handshake: push winner ID into the FIFO, and r_prio <= (winner+1) mod N_STREAMS.
  - r_prio is unchanged without a handshake; a request may be held across stalls without losing priority.
- Full (r_count == MAX_OUTSTANDING): l2_req_o=0 and no gnt_o, regardless of req_i or l2_gnt_i.
- Response routing (in-order):
  - head = FIFO[rd_ptr].
  - When not empty:
    - valid_o[head] = l2_valid_i.
    - data_o = l2_data_i.
    - l2_ready_o = ready_i[head].
    - Pop on l2_valid_i & l2_ready_o.
- Empty FIFO:
  - valid_o=0 and l2_ready_o=1, so stray data is drained.
  - l2_valid_i=1 in this state sets err_o; err_o clears only on reset or clr_i.
- FIFO accounting:
  - Push and pop in the same cycle: r_count unchanged, both pointers advance.
  - When full, a same-cycle pop does not enable a push that cycle; full is evaluated from registered r_count.
- Pointer arithmetic: pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally.
- clr_i:
  - Takes priority over push, pop and err updates.
  - Only issued when the L2 channel is idle. A response arriving after a clear hits the empty FIFO and sets err_o.
- Reset mid-transaction: all state is dropped immediately (asynchronous); no response steering survives.

Test Plan:
- Single requester: req_i=4'b0100, l2_gnt_i=1 in the same cycle → gnt_o=4'b0100, l2_addr_o = stream 2 address, outstanding_o=1. Next cycle l2_valid_i=1 with data 0xCAFE0001 → valid_o=4'b0100, data_o=0xCAFE0001, outstanding_o=0.
- Fairness: req_i=4'b1111 held, l2_gnt_i=1 every cycle, responses returned promptly → grant order 0,1,2,3,0,…; each stream gets exactly 1 grant per 4.
- Full: grant 4 reads with no responses → outstanding_o=4, l2_req_o=0 despite req_i≠0. One response → outstanding_o=3, l2_req_o=1 again next cycle.
- Ordering and backpressure: grants to 3,1,2; responses D0,D1,D2 → valid_o routes D0→3, D1→1, D2→2. Holding ready_i[1]=0 stalls l2_ready_o=0 until released.
- Stray response: empty FIFO, l2_valid_i=1 → l2_ready_o=1, valid_o=0, err_o=1 (sticky). Then clr_i=1 → err_o=0.
- Clear and reset: 2 reads outstanding, clr_i=1 → outstanding_o=0, r_prio=0, l2_req_o=0 during the clr_i cycle. Repeat with rstn_i low mid-stall → all outputs reach their reset values asynchronously.

Source files
------------

// File: rtl/udma_stream_rd_arbiter.sv
// Round-robin arbiter sharing one L2 tx read channel among N_STREAMS stream units.
// Each grant's requester ID is queued so in-order responses are steered back to it.
module udma_stream_rd_arbiter #(
  parameter int unsigned N_STREAMS       = 4,
  parameter int unsigned L2_AWIDTH_NOAL  = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ID_W            = $clog2(N_STREAMS)
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic                                  clr_i,
  input  logic [N_STREAMS-1:0]                  req_i,
  input  logic [N_STREAMS*L2_AWIDTH_NOAL-1:0]   addr_i,
  input  logic [N_STREAMS*2-1:0]                datasize_i,
  output logic [N_STREAMS-1:0]                  gnt_o,
  output logic [N_STREAMS-1:0]                  valid_o,
  output logic [DATA_WIDTH-1:0]                 data_o,
  input  logic [N_STREAMS-1:0]                  ready_i,
  output logic                                  l2_req_o,
  output logic [L2_AWIDTH_NOAL-1:0]             l2_addr_o,
  output logic [1:0]                            l2_datasize_o,
  input  logic                                  l2_gnt_i,
  input  logic                                  l2_valid_i,
  input  logic [DATA_WIDTH-1:0]                 l2_data_i,
  output logic                                  l2_ready_o,
  output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
  output logic                                  err_o
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  prio_q, prio_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q;
  logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];

  logic [ID_W-1:0]  winner_c;
  logic [ID_W-1:0]  head_c;
  logic             full_c, empty_c, push_c, pop_c;

  assign full_c  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty_c = (count_q == '0);
  assign head_c  = fifo_q[rd_ptr_q];

  // Winner: first requester at or after the priority pointer, wrapping.
  always_comb begin
    logic        found;
    int unsigned idx;
    winner_c = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N_STREAMS; i++) begin
      idx = (32'(prio_q) + i) % N_STREAMS;
      if (!found && req_i[ID_W'(idx)]) begin
        found    = 1'b1;
        winner_c = ID_W'(idx);
      end
    end
  end

  always_comb begin
    l2_req_o      = (|req_i) && !full_c && !clr_i;
    l2_addr_o     = addr_i[32'(winner_c)*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
    l2_datasize_o = datasize_i[32'(winner_c)*2 +: 2];
    push_c        = l2_req_o && l2_gnt_i;
    gnt_o         = push_c ? (N_STREAMS'(1) << winner_c) : '0;

    // Empty FIFO keeps ready high so stray data is drained rather than stalling L2.
    data_o        = l2_data_i;
    valid_o       = '0;
    l2_ready_o    = 1'b1;
    if (!empty_c) begin
      valid_o    = l2_valid_i ? (N_STREAMS'(1) << head_c) : '0;
      l2_ready_o = ready_i[head_c];
    end
    pop_c         = !empty_c && l2_valid_i && l2_ready_o;

    prio_d        = push_c ? ID_W'((32'(winner_c) + 1) % N_STREAMS) : prio_q;
    count_d       = count_q;
    if (push_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (pop_c && !push_c) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prio_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else if (clr_i) begin
      prio_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= winner_c;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      prio_q  <= prio_d;
      count_q <= count_d;
      if (empty_c && l2_valid_i) err_q <= 1'b1;
    end
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_udma_stream_rd_arbiter.sv
// Directed self-checking bench for udma_stream_rd_arbiter (4 streams, depth 4).
module tb_udma_stream_rd_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        clr_i;
  logic [3:0]  req_i;
  logic [63:0] addr_i;
  logic [7:0]  datasize_i;
  logic [3:0]  gnt_o;
  logic [3:0]  valid_o;
  logic [31:0] data_o;
  logic [3:0]  ready_i;
  logic        l2_req_o;
  logic [15:0] l2_addr_o;
  logic [1:0]  l2_datasize_o;
  logic        l2_gnt_i;
  logic        l2_valid_i;
  logic [31:0] l2_data_i;
  logic        l2_ready_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int n_checks = 0;
  int n_fail   = 0;

  udma_stream_rd_arbiter dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(clr_i),
    .req_i(req_i), .addr_i(addr_i), .datasize_i(datasize_i),
    .gnt_o(gnt_o), .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o), .l2_datasize_o(l2_datasize_o),
    .l2_gnt_i(l2_gnt_i), .l2_valid_i(l2_valid_i), .l2_data_i(l2_data_i),
    .l2_ready_o(l2_ready_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] exp_addr(input int k);
    return 16'h1000 + 16'(k) * 16'h0111;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    clr_i = 1'b0; req_i = '0; l2_gnt_i = 1'b0;
    l2_valid_i = 1'b0; l2_data_i = '0; ready_i = 4'b1111;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn_i = 1'b0;
    #12;
    n_checks++;
    if (gnt_o !== 4'b0000 || valid_o !== 4'b0000 || l2_req_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs: gnt=%b valid=%b req=%b, want 0000 0000 0", gnt_o, valid_o, l2_req_o);
    end
    n_checks++;
    if (outstanding_o !== 3'd0 || err_o !== 1'b0 || l2_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_state: outst=%0d err=%b ready=%b, want 0 0 1", outstanding_o, err_o, l2_ready_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_i = 4'b0100; l2_gnt_i = 1'b1;
    #1;
    n_checks++;
    if (gnt_o !== 4'b0100 || l2_addr_o !== exp_addr(2) || l2_datasize_o !== 2'd2) begin
      n_fail++; $display("FAIL single_gnt: gnt=%b addr=%h ds=%0d, want 0100 %h 2", gnt_o, l2_addr_o, l2_datasize_o, exp_addr(2));
    end
    tick();
    n_checks++;
    if (outstanding_o !== 3'd1) begin
      n_fail++; $display("FAIL single_outst1: got %0d want 1", outstanding_o);
    end
    req_i = '0; l2_gnt_i = 1'b0; l2_valid_i = 1'b1; l2_data_i = 32'hCAFE0001;
    #1;
    n_checks++;
    if (valid_o !== 4'b0100 || data_o !== 32'hCAFE0001 || l2_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL single_rsp: valid=%b data=%h ready=%b, want 0100 cafe0001 1", valid_o, data_o, l2_ready_o);
    end
    tick();
    l2_valid_i = 1'b0;
    n_checks++;
    if (outstanding_o !== 3'd0) begin
      n_fail++; $display("FAIL single_outst0: got %0d want 0", outstanding_o);
    end
  endtask

  task automatic test_fairness();
    int cnt [4];
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    // Clear returns the priority pointer to stream 0 and blocks requests that cycle.
    req_i = 4'b1111; clr_i = 1'b1;
    #1;
    n_checks++;
    if (l2_req_o !== 1'b0) begin
      n_fail++; $display("FAIL fair_clr_req: got %b want 0", l2_req_o);
    end
    tick();
    clr_i = 1'b0; l2_gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      l2_valid_i = (i > 0);
      l2_data_i  = 32'hF000_0000 + 32'(i);
      #1;
      n_checks++;
      if (gnt_o !== (4'b0001 << (i % 4))) begin
        n_fail++; $display("FAIL fair_gnt%0d: got %b want %b", i, gnt_o, 4'b0001 << (i % 4));
      end
      if (i > 0) begin
        n_checks++;
        if (valid_o !== (4'b0001 << ((i - 1) % 4))) begin
          n_fail++; $display("FAIL fair_rsp%0d: got %b want %b", i, valid_o, 4'b0001 << ((i - 1) % 4));
        end
      end
      for (int k = 0; k < 4; k++) if (gnt_o[k]) cnt[k]++;
      tick();
    end
    req_i = '0; l2_gnt_i = 1'b0; l2_valid_i = 1'b1;
    #1;
    n_checks++;
    if (valid_o !== 4'b1000) begin
      n_fail++; $display("FAIL fair_last_rsp: got %b want 1000", valid_o);
    end
    tick();
    l2_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (cnt[k] !== 2) begin
        n_fail++; $display("FAIL fair_count%0d: got %0d want 2", k, cnt[k]);
      end
    end
    n_checks++;
    if (outstanding_o !== 3'd0) begin
      n_fail++; $display("FAIL fair_drain: got %0d want 0", outstanding_o);
    end
  endtask

  task automatic test_full();
    req_i = 4'b1111; l2_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (gnt_o !== (4'b0001 << i)) begin
        n_fail++; $display("FAIL full_gnt%0d: got %b want %b", i, gnt_o, 4'b0001 << i);
      end
      tick();
    end
    n_checks++;
    if (outstanding_o !== 3'd4) begin
      n_fail++; $display("FAIL full_outst4: got %0d want 4", outstanding_o);
    end
    n_checks++;
    if (l2_req_o !== 1'b0 || gnt_o !== 4'b0000) begin
      n_fail++; $display("FAIL full_block: req=%b gnt=%b want 0 0000", l2_req_o, gnt_o);
    end
    l2_valid_i = 1'b1; l2_data_i = 32'h0000_00A0;
    #1;
    n_checks++;
    if (valid_o !== 4'b0001 || l2_req_o !== 1'b0 || gnt_o !== 4'b0000) begin
      n_fail++; $display("FAIL full_pop_nopush: valid=%b req=%b gnt=%b want 0001 0 0000", valid_o, l2_req_o, gnt_o);
    end
    tick();
    l2_valid_i = 1'b0; l2_gnt_i = 1'b0;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd3 || l2_req_o !== 1'b1) begin
      n_fail++; $display("FAIL full_reopen: outst=%0d req=%b want 3 1", outstanding_o, l2_req_o);
    end
    req_i = '0; l2_valid_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      n_checks++;
      if (valid_o !== (4'b0001 << i)) begin
        n_fail++; $display("FAIL full_drain%0d: got %b want %b", i, valid_o, 4'b0001 << i);
      end
      tick();
    end
    l2_valid_i = 1'b0;
    n_checks++;
    if (outstanding_o !== 3'd0) begin
      n_fail++; $display("FAIL full_empty: got %0d want 0", outstanding_o);
    end
  endtask

  task automatic test_order();
    logic [3:0] reqs [3];
    reqs[0] = 4'b1000; reqs[1] = 4'b0010; reqs[2] = 4'b0100;
    l2_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_i = reqs[i];
      #1;
      n_checks++;
      if (gnt_o !== reqs[i]) begin
        n_fail++; $display("FAIL order_gnt%0d: got %b want %b", i, gnt_o, reqs[i]);
      end
      tick();
    end
    req_i = '0; l2_gnt_i = 1'b0;
    l2_valid_i = 1'b1; l2_data_i = 32'hD0D0_0000;
    #1;
    n_checks++;
    if (valid_o !== 4'b1000 || data_o !== 32'hD0D0_0000) begin
      n_fail++; $display("FAIL order_d0: valid=%b data=%h want 1000 d0d00000", valid_o, data_o);
    end
    tick();
    l2_data_i = 32'hD1D1_1111; ready_i = 4'b1101;
    for (int s = 0; s < 2; s++) begin
      #1;
      n_checks++;
      if (valid_o !== 4'b0010 || l2_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL order_stall%0d: valid=%b ready=%b want 0010 0", s, valid_o, l2_ready_o);
      end
      tick();
      n_checks++;
      if (outstanding_o !== 3'd2) begin
        n_fail++; $display("FAIL order_stall_outst%0d: got %0d want 2", s, outstanding_o);
      end
    end
    ready_i = 4'b1111;
    #1;
    n_checks++;
    if (valid_o !== 4'b0010 || l2_ready_o !== 1'b1 || data_o !== 32'hD1D1_1111) begin
      n_fail++; $display("FAIL order_d1: valid=%b ready=%b data=%h want 0010 1 d1d11111", valid_o, l2_ready_o, data_o);
    end
    tick();
    l2_data_i = 32'hD2D2_2222;
    #1;
    n_checks++;
    if (valid_o !== 4'b0100) begin
      n_fail++; $display("FAIL order_d2: got %b want 0100", valid_o);
    end
    tick();
    l2_valid_i = 1'b0;
    n_checks++;
    if (outstanding_o !== 3'd0) begin
      n_fail++; $display("FAIL order_empty: got %0d want 0", outstanding_o);
    end
  endtask

  task automatic test_stray();
    l2_valid_i = 1'b1; l2_data_i = 32'hBAD0_0000; ready_i = 4'b0000;
    #1;
    n_checks++;
    if (l2_ready_o !== 1'b1 || valid_o !== 4'b0000) begin
      n_fail++; $display("FAIL stray_drain: ready=%b valid=%b want 1 0000", l2_ready_o, valid_o);
    end
    tick();
    l2_valid_i = 1'b0; ready_i = 4'b1111;
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++; $display("FAIL stray_err: got %b want 1", err_o);
    end
    tick();
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++; $display("FAIL stray_sticky: got %b want 1", err_o);
    end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL stray_clr: got %b want 0", err_o);
    end
  endtask

  task automatic test_clear_reset();
    l2_gnt_i = 1'b1;
    req_i = 4'b0001; tick();
    req_i = 4'b0010; tick();
    n_checks++;
    if (outstanding_o !== 3'd2) begin
      n_fail++; $display("FAIL clr_setup: got %0d want 2", outstanding_o);
    end
    req_i = 4'b1111; clr_i = 1'b1;
    #1;
    n_checks++;
    if (l2_req_o !== 1'b0 || gnt_o !== 4'b0000) begin
      n_fail++; $display("FAIL clr_block: req=%b gnt=%b want 0 0000", l2_req_o, gnt_o);
    end
    tick();
    clr_i = 1'b0; l2_gnt_i = 1'b0;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd0 || l2_addr_o !== exp_addr(0) || l2_datasize_o !== 2'd0) begin
      n_fail++; $display("FAIL clr_state: outst=%0d addr=%h ds=%0d want 0 %h 0", outstanding_o, l2_addr_o, l2_datasize_o, exp_addr(0));
    end
    l2_gnt_i = 1'b1;
    tick(); tick();
    req_i = '0; l2_gnt_i = 1'b0; l2_valid_i = 1'b1; ready_i = 4'b0000;
    #1;
    n_checks++;
    if (valid_o !== 4'b0001 || l2_ready_o !== 1'b0 || outstanding_o !== 3'd2) begin
      n_fail++; $display("FAIL rst_stall: valid=%b ready=%b outst=%0d want 0001 0 2", valid_o, l2_ready_o, outstanding_o);
    end
    #2;
    rstn_i = 1'b0;
    #1;
    n_checks++;
    if (outstanding_o !== 3'd0 || valid_o !== 4'b0000 || l2_ready_o !== 1'b1 ||
        err_o !== 1'b0 || gnt_o !== 4'b0000 || l2_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: outst=%0d valid=%b ready=%b err=%b gnt=%b req=%b want 0 0000 1 0 0000 0",
                         outstanding_o, valid_o, l2_ready_o, err_o, gnt_o, l2_req_o);
    end
    idle_inputs();
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick();
    req_i = 4'b1111;
    #1;
    n_checks++;
    if (l2_addr_o !== exp_addr(0) || err_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_prio: addr=%h err=%b want %h 0", l2_addr_o, err_o, exp_addr(0));
    end
    req_i = '0;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      addr_i[k*16 +: 16]   = exp_addr(k);
      datasize_i[k*2 +: 2] = 2'(k);
    end
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_order();
    test_stray();
    test_clear_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
